// File: rtl/f_fetch_pc.sv
// Fetch-stage PC register and instruction-memory request sequencer.
// Holds one fetched instruction for F/D and tracks branch redirects that arrive ahead of their delay slot.
module f_fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        d_redirect,
  input  logic [31:0] npc,
  input  logic        exc_flush,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_adel
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_KILL} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic        r_pend_v;
  logic        r_f_valid;
  logic [31:0] r_f_pc;
  logic [31:0] r_f_instr;
  logic        r_f_adel;

  logic        w_legal;
  logic        w_flush;
  logic [31:0] w_flush_pc;
  logic        w_req_state;
  logic        w_granted;
  logic        w_consume;
  logic [31:0] w_next_pc;

  assign w_legal     = (r_pc[1:0] == 2'b00) && (r_pc >= IM_LO) && (r_pc <= IM_HI);
  assign w_flush     = exc_flush | eret;
  assign w_flush_pc  = exc_flush ? EXC_PC : epc;
  assign w_req_state = reset_n && (r_state == S_REQ) && w_legal;
  assign w_granted   = w_req_state && im_gnt;
  assign w_consume   = (r_state == S_HOLD) && !stall && !w_flush;
  assign w_next_pc   = d_redirect ? npc : (r_pend_v ? r_pend_pc : r_pc + 32'd4);

  // A flush withdraws the request unless the memory already granted it this cycle.
  assign im_req  = w_req_state && (!w_flush || im_gnt);
  assign im_addr = r_pc;
  assign f_valid = r_f_valid;
  assign f_pc    = r_f_pc;
  assign f_instr = r_f_instr;
  assign f_adel  = r_f_adel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_pend_pc <= 32'd0;
      r_pend_v  <= 1'b0;
      r_f_valid <= 1'b0;
      r_f_pc    <= RESET_PC;
      r_f_instr <= 32'd0;
      r_f_adel  <= 1'b0;
    end else if (w_flush) begin
      r_pc      <= w_flush_pc;
      r_pend_v  <= 1'b0;
      r_f_valid <= 1'b0;
      // A response landing in the flush cycle itself already settles the outstanding request.
      case (r_state)
        S_REQ:   r_state <= w_granted ? S_KILL : S_REQ;
        S_WAIT:  r_state <= im_rvalid ? S_REQ : S_KILL;
        S_KILL:  r_state <= im_rvalid ? S_REQ : S_KILL;
        default: r_state <= S_REQ;
      endcase
    end else begin
      if (w_consume) begin
        r_pend_v <= 1'b0;
      end else if (d_redirect) begin
        r_pend_v  <= 1'b1;
        r_pend_pc <= npc;
      end
      case (r_state)
        S_REQ: begin
          if (!w_legal) begin
            r_state   <= S_HOLD;
            r_f_valid <= 1'b1;
            r_f_pc    <= r_pc;
            r_f_instr <= 32'd0;
            r_f_adel  <= 1'b1;
          end else if (w_granted) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (im_rvalid) begin
            r_state   <= S_HOLD;
            r_f_valid <= 1'b1;
            r_f_pc    <= r_pc;
            r_f_instr <= im_rdata;
            r_f_adel  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_pc      <= w_next_pc;
            r_state   <= S_REQ;
            r_f_valid <= 1'b0;
          end
        end
        default: begin
          if (im_rvalid) r_state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f_fetch_pc.sv
// Self-checking bench for f_fetch_pc: table-driven fetch sequence plus hand-written flush/redirect cases.
// A small instruction-memory responder feeds the DUT; expected deliveries go through a scoreboard queue.
module tb_f_fetch_pc;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        d_redirect;
  logic [31:0] npc;
  logic        exc_flush;
  logic        eret;
  logic [31:0] epc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_adel;

  always #5 clk = ~clk;

  f_fetch_pc #(
    .RESET_PC(RESET_PC), .EXC_PC(EXC_PC), .IM_LO(IM_LO), .IM_HI(IM_HI)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .d_redirect(d_redirect), .npc(npc),
    .exc_flush(exc_flush), .eret(eret), .epc(epc),
    .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_adel(f_adel)
  );

  typedef struct {
    logic [31:0] pc;
    int          stall_n;
    logic        redir;
    logic [31:0] npc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  vec_t        tbl [9];
  exp_t        sb_q [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          resp_wait = 0;
  int          resp_lat = 1;
  int          first_gnt = -1;
  int          first_rise = -1;
  logic        gnt_en;
  logic [31:0] resp_addr;
  logic [31:0] last_gnt_addr;
  logic        s_im_req, s_f_valid, s_f_adel, s_prev_fv, got_rise;
  logic [31:0] s_im_addr, s_f_pc, s_f_instr;

  function automatic logic is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= IM_LO) && (a <= IM_HI);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.adel  = !is_legal(a);
    e.instr = e.adel ? 32'h0 : mem_word(a);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // One clock cycle: drive memory response, sample at negedge, advance past posedge.
  task automatic run_cycle();
    exp_t e;
    im_rvalid = (resp_wait == 1);
    im_rdata  = im_rvalid ? mem_word(resp_addr) : 32'hDEAD_BEEF;
    im_gnt    = gnt_en;
    @(negedge clk);
    s_im_req  = im_req;
    s_im_addr = im_addr;
    s_f_valid = f_valid;
    s_f_pc    = f_pc;
    s_f_instr = f_instr;
    s_f_adel  = f_adel;
    if (resp_wait > 0) resp_wait--;
    if (im_req) check("req_addr_legal", {31'd0, is_legal(im_addr)}, 32'd1);
    if (im_req && im_gnt) begin
      resp_wait     = resp_lat;
      resp_addr     = im_addr;
      last_gnt_addr = im_addr;
      if (first_gnt < 0) first_gnt = cyc;
      $display("cyc %0d grant addr=%h", cyc, im_addr);
    end
    if (f_valid && !s_prev_fv) begin
      got_rise = 1'b1;
      if (first_rise < 0) first_rise = cyc;
      $display("cyc %0d deliver pc=%h instr=%h adel=%0d", cyc, f_pc, f_instr, f_adel);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_delivery: got pc %h want none", f_pc);
      end else begin
        e = sb_q.pop_front();
        check("f_pc", f_pc, e.pc);
        check("f_instr", f_instr, e.instr);
        check("f_adel", {31'd0, f_adel}, {31'd0, e.adel});
      end
    end
    s_prev_fv = f_valid;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_deliver(input string name);
    int n;
    n = 0;
    got_rise = 1'b0;
    while (!got_rise && n < 20) begin
      run_cycle();
      n++;
    end
    if (!got_rise) begin
      total++;
      bad++;
      $display("FAIL %s: got no delivery in 20 cycles want one", name);
    end
  endtask

  task automatic consume(input logic redir, input logic [31:0] target);
    stall      = 1'b0;
    d_redirect = redir;
    npc        = target;
    run_cycle();
    check("consume_in_hold", {31'd0, s_f_valid}, 32'd1);
    stall      = 1'b1;
    d_redirect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h0000_3000, 0, 1'b0, 32'h0};
    tbl[1] = '{32'h0000_3004, 4, 1'b0, 32'h0};
    tbl[2] = '{32'h0000_3008, 0, 1'b1, 32'h0000_3002};
    tbl[3] = '{32'h0000_3002, 0, 1'b1, 32'h0000_7000};
    tbl[4] = '{32'h0000_7000, 0, 1'b1, 32'h0000_6FFC};
    tbl[5] = '{32'h0000_6FFC, 0, 1'b0, 32'h0};
    tbl[6] = '{32'h0000_7000, 0, 1'b1, 32'h0000_2FFC};
    tbl[7] = '{32'h0000_2FFC, 0, 1'b1, 32'h0000_3010};
    tbl[8] = '{32'h0000_3010, 0, 1'b0, 32'h0};

    reset_n = 1'b0; stall = 1'b1; d_redirect = 1'b0; npc = 32'h0;
    exc_flush = 1'b0; eret = 1'b0; epc = 32'h0;
    gnt_en = 1'b1; im_gnt = 1'b1; im_rvalid = 1'b0; im_rdata = 32'h0;
    s_prev_fv = 1'b0; got_rise = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_im_req", {31'd0, im_req}, 32'd0);
    check("rst_f_valid", {31'd0, f_valid}, 32'd0);
    check("rst_f_pc", f_pc, RESET_PC);
    check("rst_f_instr", f_instr, 32'd0);
    check("rst_f_adel", {31'd0, f_adel}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Table: each record is one delivered instruction and how it is consumed.
    for (int i = 0; i < 9; i++) begin
      sb_q.push_back(mk_exp(tbl[i].pc));
      wait_deliver("deliver_tbl");
      if (i == 0) check("first_latency", first_rise - first_gnt, 32'd2);
      for (int s = 0; s < tbl[i].stall_n; s++) begin
        run_cycle();
        check("stall_f_pc", s_f_pc, tbl[i].pc);
        check("stall_f_instr", s_f_instr, mk_exp(tbl[i].pc).instr);
        check("stall_im_req", {31'd0, s_im_req}, 32'd0);
      end
      consume(tbl[i].redir, tbl[i].npc);
      if (i < 8) begin
        run_cycle();
        check("next_im_req", {31'd0, s_im_req}, {31'd0, is_legal(tbl[i+1].pc)});
        if (is_legal(tbl[i+1].pc)) check("next_im_addr", s_im_addr, tbl[i+1].pc);
      end
    end

    // Redirect arriving while the delay slot is still in flight.
    sb_q.push_back(mk_exp(32'h0000_3014));
    sb_q.push_back(mk_exp(32'h0000_3100));
    sb_q.push_back(mk_exp(32'h0000_3104));
    run_cycle();
    check("slot_im_addr", s_im_addr, 32'h0000_3014);
    d_redirect = 1'b1; npc = 32'h0000_3100;
    run_cycle();
    d_redirect = 1'b0;
    wait_deliver("deliver_slot");
    consume(1'b0, 32'h0);
    wait_deliver("deliver_target");
    consume(1'b0, 32'h0);
    wait_deliver("deliver_after_target");

    // Exception while the request is in flight; late response must be dropped.
    resp_lat = 2;
    consume(1'b0, 32'h0);
    run_cycle();
    check("pre_flush_addr", s_im_addr, 32'h0000_3108);
    exc_flush = 1'b1;
    run_cycle();
    exc_flush = 1'b0;
    resp_lat  = 1;
    run_cycle();
    check("kill_f_valid", {31'd0, s_f_valid}, 32'd0);
    check("kill_im_req", {31'd0, s_im_req}, 32'd0);
    sb_q.push_back(mk_exp(EXC_PC));
    wait_deliver("deliver_exc");
    check("exc_gnt_addr", last_gnt_addr, EXC_PC);

    // exc_flush beats eret; then a lone eret returns to epc.
    exc_flush = 1'b1; eret = 1'b1; epc = 32'h0000_3200;
    run_cycle();
    exc_flush = 1'b0; eret = 1'b0;
    sb_q.push_back(mk_exp(EXC_PC));
    run_cycle();
    check("both_f_valid", {31'd0, s_f_valid}, 32'd0);
    check("both_im_addr", s_im_addr, EXC_PC);
    wait_deliver("deliver_both");
    eret = 1'b1;
    run_cycle();
    eret = 1'b0;
    sb_q.push_back(mk_exp(32'h0000_3200));
    wait_deliver("deliver_eret");

    // Flush in REQ with a grant in the same cycle: grant counts, response absorbed.
    consume(1'b0, 32'h0);
    exc_flush = 1'b1;
    run_cycle();
    exc_flush = 1'b0;
    check("flush_gnt_im_req", {31'd0, s_im_req}, 32'd1);
    run_cycle();
    check("flush_gnt_f_valid", {31'd0, s_f_valid}, 32'd0);
    check("flush_gnt_kill_req", {31'd0, s_im_req}, 32'd0);
    sb_q.push_back(mk_exp(EXC_PC));
    wait_deliver("deliver_flush_gnt");

    // Request held without grant, then withdrawn by eret.
    gnt_en = 1'b0;
    consume(1'b0, 32'h0);
    run_cycle();
    check("nognt_im_req", {31'd0, s_im_req}, 32'd1);
    check("nognt_im_addr", s_im_addr, 32'h0000_4184);
    run_cycle();
    check("nognt_addr_stable", s_im_addr, 32'h0000_4184);
    eret = 1'b1; epc = 32'h0000_3300;
    run_cycle();
    check("eret_req_drop", {31'd0, s_im_req}, 32'd0);
    eret = 1'b0; gnt_en = 1'b1;
    sb_q.push_back(mk_exp(32'h0000_3300));
    wait_deliver("deliver_eret2");

    check("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
